snn_frame_sequencer: RTL and testbench

Frame-level controller for the fully connected SNN.
- Drives INIT, FP_FRAME/pre_FP_FRAME and BP_FRAME/pre_BP_FRAME into the decoder bank and the training layers.
- Optionally sweeps the node-output export port after a forward frame and streams each 16-bit node mean out on a valid/ready interface.
- Sits between host control registers and the network core.

---
 rtl/snn_ctrl_pkg.sv | 24 ++
 rtl/snn_frame_timer.sv | 25 ++
 rtl/snn_frame_sequencer.sv | 172 +++++++++++++++++
 tb/tb_snn_frame_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_ctrl_pkg.sv
// Shared types and defaults for the SNN frame controller: FSM state encoding,
// export index width, default frame lengths and a saturating increment helper.
package snn_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FP, S_BP, S_EXP_SET, S_EXP_HI, S_EXP_LO, S_EXP_OUT
  } state_t;

  localparam int IDX_W        = 16;
  localparam int DEF_FP_LEN   = 256;
  localparam int DEF_BP_LEN   = 256;
  localparam int DEF_INIT_LEN = 16;
  localparam int DEF_N_NODES  = 38;

  // A run of zero iterations makes no sense; treat it as one.
  function automatic logic [15:0] eff_frames(input logic [15:0] n);
    return (n == 16'd0) ? 16'd1 : n;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/snn_frame_timer.sv
// Loadable down-counter; pre fires one count before the end, last on the final count.
module snn_frame_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] ld_val,
  output logic         pre,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (load)             cnt <= ld_val;
    else if (en && cnt != '0)  cnt <= cnt - W'(1);
  end

  assign pre  = (cnt == W'(1));
  assign last = (cnt == '0);

endmodule

// File: rtl/snn_frame_sequencer.sv
// Frame-level sequencer for the fully connected SNN: INIT, FP/BP frame pulses and
// node-output export sweep. Define SNN_FRAME_STATS_EN to add fp/bp/stall counters.
module snn_frame_sequencer
  import snn_ctrl_pkg::*;
#(
  parameter int FP_LEN   = DEF_FP_LEN,
  parameter int BP_LEN   = DEF_BP_LEN,
  parameter int INIT_LEN = DEF_INIT_LEN,
  parameter int N_NODES  = DEF_N_NODES,
  parameter int CNT_W    = 16
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        start,
  input  logic [15:0] n_frames,
  input  logic        train,
  input  logic        dump_en,
  input  logic        abort,
  output logic        INIT,
  output logic        FP_FRAME,
  output logic        pre_FP_FRAME,
  output logic        BP_FRAME,
  output logic        pre_BP_FRAME,
  output logic        NodeOutputExp_clk,
  output logic [15:0] NodeOutputExp_index,
  input  logic [15:0] NodeOutputExp_data,
  output logic [15:0] dout,
  output logic [15:0] dout_idx,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        busy,
  output logic        done
`ifdef SNN_FRAME_STATS_EN
  ,
  output logic [31:0] fp_count,
  output logic [31:0] bp_count,
  output logic [31:0] stall_cycles
`endif
);

  localparam logic [CNT_W-1:0] FP_LD    = CNT_W'(FP_LEN - 1);
  localparam logic [CNT_W-1:0] BP_LD    = CNT_W'(BP_LEN - 1);
  localparam logic [CNT_W-1:0] INIT_LD  = CNT_W'(INIT_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NODES - 1);

  state_t           state, nxt;
  logic             tload, ten, tpre, tlast;
  logic [CNT_W-1:0] tld;
  logic             eoi, last_iter, start_acc;
  logic [15:0]      n_q, iter_q;
  logic             train_q, dump_q;
  logic [IDX_W-1:0] idx_q;

  assign start_acc = (state == S_IDLE) && start && !abort;
  assign last_iter = (iter_q + 16'd1) == n_q;

  // One timer serves INIT and both frame kinds; reload on entry and on back-to-back frames.
  assign ten   = state inside {S_INIT, S_FP, S_BP};
  assign tload = start_acc || ((nxt == S_FP || nxt == S_BP) && (nxt != state || tlast));
  assign tld   = (nxt == S_INIT) ? INIT_LD : (nxt == S_BP) ? BP_LD : FP_LD;

  snn_frame_timer #(.W(CNT_W)) u_timer (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .load   (tload),
    .en     (ten),
    .ld_val (tld),
    .pre    (tpre),
    .last   (tlast)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    eoi = 1'b0;
    if (abort) nxt = S_IDLE;
    else begin
      case (state)
        S_IDLE:    if (start) nxt = S_INIT;
        S_INIT:    if (tlast) nxt = S_FP;
        S_FP: if (tlast) begin
          if (train_q)     nxt = S_BP;
          else if (dump_q) nxt = S_EXP_SET;
          else             eoi = 1'b1;
        end
        S_BP: if (tlast) begin
          if (dump_q) nxt = S_EXP_SET;
          else        eoi = 1'b1;
        end
        S_EXP_SET: nxt = S_EXP_HI;
        S_EXP_HI:  nxt = S_EXP_LO;
        S_EXP_LO:  nxt = S_EXP_OUT;
        S_EXP_OUT: if (dout_ready) begin
          if (idx_q == LAST_IDX) eoi = 1'b1;
          else                   nxt = S_EXP_SET;
        end
        default:   nxt = S_IDLE;
      endcase
      if (eoi) nxt = last_iter ? S_IDLE : S_FP;
    end
  end

  always_comb begin
    INIT         = (state == S_INIT);
    pre_FP_FRAME = (state == S_FP) && tpre;
    FP_FRAME     = (state == S_FP) && tlast;
    pre_BP_FRAME = (state == S_BP) && tpre;
    BP_FRAME     = (state == S_BP) && tlast;
    dout_valid   = (state == S_EXP_OUT);
    busy         = (state != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      n_q               <= '0;
      iter_q            <= '0;
      train_q           <= 1'b0;
      dump_q            <= 1'b0;
      idx_q             <= '0;
      dout              <= '0;
      dout_idx          <= '0;
      NodeOutputExp_clk <= 1'b0;
      done              <= 1'b0;
    end else begin
      done              <= eoi && last_iter;
      NodeOutputExp_clk <= (nxt == S_EXP_HI);
      if (start_acc) begin
        n_q     <= eff_frames(n_frames);
        train_q <= train;
        dump_q  <= dump_en;
        iter_q  <= '0;
      end
      if (eoi) iter_q <= iter_q + 16'd1;
      if (nxt == S_EXP_SET) idx_q <= (state == S_EXP_OUT) ? idx_q + IDX_W'(1) : '0;
      // Data is sampled after the strobe has fallen, while the index is still held.
      if (state == S_EXP_LO) begin
        dout     <= NodeOutputExp_data;
        dout_idx <= idx_q;
      end
      if (nxt == S_IDLE) begin
        idx_q    <= '0;
        dout     <= '0;
        dout_idx <= '0;
      end
    end
  end

  assign NodeOutputExp_index = idx_q;

`ifdef SNN_FRAME_STATS_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fp_count     <= '0;
      bp_count     <= '0;
      stall_cycles <= '0;
    end else if (start_acc) begin
      fp_count     <= '0;
      bp_count     <= '0;
      stall_cycles <= '0;
    end else begin
      if (FP_FRAME)                  fp_count     <= sat_inc(fp_count);
      if (BP_FRAME)                  bp_count     <= sat_inc(bp_count);
      if (dout_valid && !dout_ready) stall_cycles <= sat_inc(stall_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_snn_frame_sequencer.sv
// Scoreboard bench for snn_frame_sequencer: expected output events are queued with
// their cycle numbers and a negedge monitor pops and compares them.
module tb_snn_frame_sequencer;

  localparam int K_INIT = 0, K_PFP = 1, K_FP = 2, K_PBP = 3, K_BP = 4;
  localparam int K_STRB = 5, K_BEAT = 6, K_DONE = 7;

  typedef struct {
    int kind;
    int cyc;
    int d;
    int idx;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  int  p;

  logic        CLK = 1'b0, RESET_N = 1'b0;
  logic        start = 1'b0, train = 1'b0, dump_en = 1'b0, abort = 1'b0;
  logic        dout_ready = 1'b1;
  logic [15:0] n_frames = 16'd0;
  logic        INIT, FP_FRAME, pre_FP_FRAME, BP_FRAME, pre_BP_FRAME;
  logic        NodeOutputExp_clk, dout_valid, busy, done;
  logic [15:0] NodeOutputExp_index, NodeOutputExp_data, dout, dout_idx;
`ifdef SNN_FRAME_STATS_EN
  logic [31:0] fp_count, bp_count, stall_cycles;
`endif

  snn_frame_sequencer #(
    .FP_LEN(8), .BP_LEN(8), .INIT_LEN(16), .N_NODES(38), .CNT_W(16)
  ) dut (
    .CLK                 (CLK),
    .RESET_N             (RESET_N),
    .start               (start),
    .n_frames            (n_frames),
    .train               (train),
    .dump_en             (dump_en),
    .abort               (abort),
    .INIT                (INIT),
    .FP_FRAME            (FP_FRAME),
    .pre_FP_FRAME        (pre_FP_FRAME),
    .BP_FRAME            (BP_FRAME),
    .pre_BP_FRAME        (pre_BP_FRAME),
    .NodeOutputExp_clk   (NodeOutputExp_clk),
    .NodeOutputExp_index (NodeOutputExp_index),
    .NodeOutputExp_data  (NodeOutputExp_data),
    .dout                (dout),
    .dout_idx            (dout_idx),
    .dout_valid          (dout_valid),
    .dout_ready          (dout_ready),
    .busy                (busy),
    .done                (done)
`ifdef SNN_FRAME_STATS_EN
    ,
    .fp_count            (fp_count),
    .bp_count            (bp_count),
    .stall_cycles        (stall_cycles)
`endif
  );

  // Decoder-bank model: node mean = index * 3.
  assign NodeOutputExp_data = NodeOutputExp_index * 16'd3;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic string kname(int k);
    case (k)
      K_INIT:  return "init";
      K_PFP:   return "pre_fp";
      K_FP:    return "fp_frame";
      K_PBP:   return "pre_bp";
      K_BP:    return "bp_frame";
      K_STRB:  return "strobe";
      K_BEAT:  return "beat";
      default: return "done";
    endcase
  endfunction

  task automatic check_ev(int kind, int d, int idx);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got cyc=%0d d=%0d idx=%0d, required no event",
               kname(kind), cyc, d, idx);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.d != d || e.idx != idx) begin
        errors++;
        $display("FAIL ev_%s: got %s cyc=%0d d=%0d idx=%0d, required %s cyc=%0d d=%0d idx=%0d",
                 kname(kind), kname(kind), cyc, d, idx, kname(e.kind), e.cyc, e.d, e.idx);
      end
    end
  endtask

  logic prev_strb = 1'b0;
  always @(negedge CLK) begin
    if (INIT)         check_ev(K_INIT, 0, 0);
    if (pre_FP_FRAME) check_ev(K_PFP, 0, 0);
    if (FP_FRAME)     check_ev(K_FP, 0, 0);
    if (pre_BP_FRAME) check_ev(K_PBP, 0, 0);
    if (BP_FRAME)     check_ev(K_BP, 0, 0);
    if (NodeOutputExp_clk && !prev_strb) check_ev(K_STRB, 0, int'(NodeOutputExp_index));
    if (dout_valid && dout_ready)        check_ev(K_BEAT, int'(dout), int'(dout_idx));
    if (done)         check_ev(K_DONE, 0, 0);
    prev_strb <= NodeOutputExp_clk;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_to(int t);
    while (cyc < t) tick();
  endtask

  task automatic pushe(int kind, int c, int d = 0, int idx = 0);
    ev_t e;
    e = '{kind, c, d, idx};
    q.push_back(e);
  endtask

  task automatic push_init(int base);
    for (int i = 0; i < 16; i++) pushe(K_INIT, base + i);
  endtask

  task automatic do_start(input logic [15:0] n, input logic tr, input logic de, output int ps);
    n_frames = n;
    train    = tr;
    dump_en  = de;
    start    = 1'b1;
    ps       = cyc + 1;
    tick();
    start    = 1'b0;
  endtask

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, want);
    end
  endtask

  task automatic chk_zero(string name);
    chk(name, {INIT, pre_FP_FRAME, FP_FRAME, pre_BP_FRAME, BP_FRAME, NodeOutputExp_clk,
               dout_valid, busy, done, NodeOutputExp_index, dout, dout_idx}, 64'd0);
  endtask

  task automatic drain(int t, string name);
    wait_to(t);
    chk(name, q.size(), 0);
  endtask

  initial begin
    repeat (3) tick();
    chk_zero("reset_state");
    RESET_N = 1'b1;
    tick();

    // Two forward frames, no training, no export.
    do_start(16'd2, 1'b0, 1'b0, p);
    push_init(p);
    pushe(K_PFP, p + 22); pushe(K_FP, p + 23);
    pushe(K_PFP, p + 30); pushe(K_FP, p + 31);
    pushe(K_DONE, p + 32);
    drain(p + 36, "t1_queue");
    chk("t1_idle", busy, 0);

    // Training run: BP frame follows FP frame.
    do_start(16'd1, 1'b1, 1'b0, p);
    push_init(p);
    pushe(K_PFP, p + 22); pushe(K_FP, p + 23);
    pushe(K_PBP, p + 30); pushe(K_BP, p + 31);
    pushe(K_DONE, p + 32);
    drain(p + 36, "t2_queue");

    // Export sweep with consumer always ready.
    dout_ready = 1'b1;
    do_start(16'd1, 1'b0, 1'b1, p);
    push_init(p);
    pushe(K_PFP, p + 22); pushe(K_FP, p + 23);
    for (int i = 0; i < 38; i++) begin
      pushe(K_STRB, p + 25 + 4 * i, 0, i);
      pushe(K_BEAT, p + 27 + 4 * i, 3 * i, i);
    end
    pushe(K_DONE, p + 176);
    drain(p + 180, "t3_queue");

    // Export sweep with a 10-cycle stall at index 5.
    do_start(16'd1, 1'b0, 1'b1, p);
    push_init(p);
    pushe(K_PFP, p + 22); pushe(K_FP, p + 23);
    for (int i = 0; i < 38; i++) begin
      pushe(K_STRB, p + 25 + 4 * i + ((i > 5) ? 10 : 0), 0, i);
      pushe(K_BEAT, p + 27 + 4 * i + ((i >= 5) ? 10 : 0), 3 * i, i);
    end
    pushe(K_DONE, p + 186);
    wait_to(p + 46);
    dout_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      wait_to(p + 47 + k);
      chk("t4_hold", {dout_valid, dout_idx, dout}, {1'b1, 16'd5, 16'd15});
    end
    wait_to(p + 57);
    dout_ready = 1'b1;
    drain(p + 190, "t4_queue");
`ifdef SNN_FRAME_STATS_EN
    chk("t4_stall_cycles", stall_cycles, 10);
    chk("t4_fp_count", fp_count, 1);
    chk("t4_bp_count", bp_count, 0);
`endif

    // Abort at FP count 3.
    do_start(16'd1, 1'b0, 1'b0, p);
    push_init(p);
    wait_to(p + 19);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_zero("t5_abort_fp");
    drain(p + 36, "t5a_queue");

    // Abort while the export strobe is high.
    do_start(16'd1, 1'b0, 1'b1, p);
    push_init(p);
    pushe(K_PFP, p + 22); pushe(K_FP, p + 23);
    pushe(K_STRB, p + 25, 0, 0);
    wait_to(p + 25);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_zero("t5_abort_exp");
    drain(p + 40, "t5b_queue");

    // start while busy must not disturb the latched run settings.
    do_start(16'd1, 1'b1, 1'b0, p);
    push_init(p);
    pushe(K_PFP, p + 22); pushe(K_FP, p + 23);
    pushe(K_PBP, p + 30); pushe(K_BP, p + 31);
    pushe(K_DONE, p + 32);
    wait_to(p + 18);
    n_frames = 16'd5;
    train    = 1'b0;
    dump_en  = 1'b1;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    drain(p + 36, "t6a_queue");

    // Asynchronous reset in the middle of a BP frame.
    do_start(16'd1, 1'b1, 1'b0, p);
    push_init(p);
    pushe(K_PFP, p + 22); pushe(K_FP, p + 23);
    wait_to(p + 27);
    #2 RESET_N = 1'b0;
    #1 chk_zero("t6_async_reset");
    tick();
    RESET_N = 1'b1;
    tick();
    drain(p + 36, "t6b_queue");

    // Fresh run after reset starts with INIT again.
    do_start(16'd1, 1'b0, 1'b0, p);
    push_init(p);
    pushe(K_PFP, p + 22); pushe(K_FP, p + 23);
    pushe(K_DONE, p + 24);
    drain(p + 28, "t6c_queue");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
